// File: rtl/apb_pkg.sv
// Shared APB master types: FSM state encoding, address width and the
// per-data-width alignment mask used for the misalignment check.
package apb_pkg;

    localparam int APB_AWIDTH = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [1:0] align_mask(input int dwidth);
        case (dwidth)
            32:      align_mask = 2'b11;
            16:      align_mask = 2'b01;
            default: align_mask = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS-phase wait cycles; expired_o flags the cycle whose wait would reach TIMEOUT_CYCLES.
// Saturating, never wraps; TIMEOUT_CYCLES=0 ties expired_o low permanently.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic PCLK,
    input  logic PRESETN,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && (cnt_q != SAT)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Fires during the wait cycle whose increment lands on TIMEOUT_CYCLES.
    assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && (cnt_q == LAST);

endmodule

// File: rtl/apb3_master_bridge.sv
// Valid/ready command stream to single APB3 transfers, one response per command.
// Zero-wait latency accept->rsp_valid is 3 cycles; one transfer outstanding, cmd_ready low until rsp handshake.
module apb3_master_bridge
    import apb_pkg::*;
#(
    parameter int APB_DWIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter bit ALIGN_CHECK    = 1'b1
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [APB_AWIDTH-1:0] cmd_addr,
    input  logic [APB_DWIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DWIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [APB_AWIDTH-1:0] PADDR,
    output logic [APB_DWIDTH-1:0] PWDATA,
    input  logic [APB_DWIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_state_t            state_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [APB_AWIDTH-1:0] paddr_q;
    logic [APB_DWIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic [APB_DWIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;

    logic misaligned;
    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    assign misaligned  = ALIGN_CHECK && (|(cmd_addr[1:0] & align_mask(APB_DWIDTH)));
    assign cmd_ready   = (state_q == IDLE);
    assign timer_clear = (state_q == IDLE) && cmd_valid;
    assign timer_en    = (state_q == ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .PCLK     (PCLK),
        .PRESETN  (PRESETN),
        .clear_i  (timer_clear),
        .enable_i (timer_en),
        .expired_o(timer_expired)
    );

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite_q <= cmd_write;
                        paddr_q  <= cmd_addr;
                        pwdata_q <= cmd_write ? cmd_wdata : '0;
                        if (misaligned) begin
                            // Rejected locally: respond without touching the bus.
                            state_q       <= RESP;
                            rsp_valid_q   <= 1'b1;
                            rsp_rdata_q   <= '0;
                            rsp_err_q     <= 1'b1;
                            rsp_timeout_q <= 1'b0;
                        end else begin
                            state_q <= SETUP;
                            psel_q  <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        state_q       <= RESP;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
                        rsp_err_q     <= PSLVERR;
                        rsp_timeout_q <= 1'b0;
                    end else if (timer_expired) begin
                        state_q       <= RESP;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
